// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch
// Purpose  : In-order instruction fetch. Issues word reads to instruction
//            memory under a credit limit, buffers returned words with their
//            PCs in a small FIFO for decode, and flushes/discards stale work
//            on redirect.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
   parameter int              XLEN            = 32,
   parameter int              ILEN            = 32,
   parameter logic [XLEN-1:0] RESET_PC        = '0,
   parameter int              FIFO_DEPTH      = 2,
   parameter int              MAX_OUTSTANDING = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req_valid,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_req_ready,
   input  logic            imem_resp_valid,
   input  logic [XLEN-1:0] imem_resp_data,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [ILEN-1:0] instr_bits,
   output logic [XLEN-1:0] instr_pc,
   output logic            misaligned_fault
);

   localparam int FW = $clog2(FIFO_DEPTH + 1);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int OW = $clog2(MAX_OUTSTANDING + 1);
   localparam int QW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

   // Architectural state
   logic [XLEN-1:0] fetch_pc;
   logic            fault;
   logic [ILEN-1:0] fifo_bits [FIFO_DEPTH];
   logic [XLEN-1:0] fifo_pc   [FIFO_DEPTH];
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr;
   logic [FW-1:0]   fifo_count;
   logic [XLEN-1:0] pcq [MAX_OUTSTANDING];
   logic [QW-1:0]   q_head;
   logic [QW-1:0]   q_tail;
   logic [OW-1:0]   outstanding;
   logic [OW-1:0]   discard;

   // Per-cycle decisions
   logic credit_ok;
   logic req_valid_int;
   logic accept;
   logic resp_drop;
   logic resp_keep;
   logic resp_any;
   logic push;
   logic pop;

   // Credit check, handshake qualification and response classification
   always_comb begin
      credit_ok     = ((int'(outstanding) + int'(discard) + int'(fifo_count)) < FIFO_DEPTH) &&
                      ((int'(outstanding) + int'(discard)) < MAX_OUTSTANDING);
      req_valid_int = !rst && !redirect_valid && !fault && credit_ok;
      accept        = req_valid_int && imem_req_ready;
      resp_drop     = imem_resp_valid && (discard != '0);
      // A response with no recorded request is spurious and ignored.
      resp_keep     = imem_resp_valid && (discard == '0) && (outstanding != '0);
      resp_any      = resp_drop || resp_keep;
      push          = resp_keep && !redirect_valid;
      pop           = !rst && (fifo_count != '0) && instr_ready && !redirect_valid;
   end

   // Fetch PC, fault flag, request tracking and instruction FIFO
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc    <= RESET_PC;
         fault       <= 1'b0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         fifo_count  <= '0;
         q_head      <= '0;
         q_tail      <= '0;
         outstanding <= '0;
         discard     <= '0;
      end else if (redirect_valid) begin
         // Everything in flight becomes stale; the response landing this
         // cycle is already accounted for and is simply dropped.
         fetch_pc    <= redirect_pc;
         fault       <= |redirect_pc[1:0];
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         fifo_count  <= '0;
         q_head      <= '0;
         q_tail      <= '0;
         outstanding <= '0;
         discard     <= discard + outstanding - OW'(resp_any);
      end else begin
         if (accept) begin
            fetch_pc    <= fetch_pc + XLEN'(4);
            pcq[q_tail] <= fetch_pc;
            q_tail      <= (q_tail == QW'(MAX_OUTSTANDING - 1)) ? '0 : q_tail + QW'(1);
         end
         if (resp_keep) begin
            q_head <= (q_head == QW'(MAX_OUTSTANDING - 1)) ? '0 : q_head + QW'(1);
         end
         outstanding <= outstanding + OW'(accept) - OW'(resp_keep);
         if (resp_drop) begin
            discard <= discard - OW'(1);
         end
         if (push) begin
            fifo_bits[wr_ptr] <= imem_resp_data[ILEN-1:0];
            fifo_pc[wr_ptr]   <= pcq[q_head];
            wr_ptr            <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
         end
         fifo_count <= fifo_count + FW'(push) - FW'(pop);
      end
   end

   // Output drive; everything reads as zero while reset is held
   always_comb begin
      imem_req_valid   = req_valid_int;
      imem_req_addr    = rst ? '0 : fetch_pc;
      instr_valid      = !rst && (fifo_count != '0);
      instr_bits       = rst ? '0 : fifo_bits[rd_ptr];
      instr_pc         = rst ? '0 : fifo_pc[rd_ptr];
      misaligned_fault = !rst && fault;
   end

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_fetch
// Purpose  : Randomized scoreboard bench for instruction_fetch with a
//            behavioural memory model and an instruction-stream reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

   localparam logic [31:0] RESET_PC = 32'h0;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready = 1'b0;
   logic        imem_resp_valid = 1'b0;
   logic [31:0] imem_resp_data = '0;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [31:0] instr_bits;
   logic [31:0] instr_pc;
   logic        misaligned_fault;

   instruction_fetch #(
      .XLEN(32), .ILEN(32), .RESET_PC(RESET_PC), .FIFO_DEPTH(2), .MAX_OUTSTANDING(2)
   ) dut (
      .clk(clk), .rst(rst),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
      .imem_req_ready(imem_req_ready),
      .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_bits(instr_bits), .instr_pc(instr_pc),
      .misaligned_fault(misaligned_fault)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] bits;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] mem_addr_q[$];
   int          mem_due_q[$];
   int          checks = 0;
   int          fails = 0;
   int          pops = 0;
   int          cyc = 0;
   int          last_due = 0;

   // Memory contents: a fixed scramble of the address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A3C_96E1;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One cycle of stimulus plus the memory model.
   task automatic step(input bit rs, input bit rv, input logic [31:0] rp,
                       input bit mrdy, input bit drdy, input int lat);
      int due;
      @(negedge clk);
      cyc++;
      rst             = rs;
      redirect_valid  = rv;
      redirect_pc     = rp;
      imem_req_ready  = mrdy;
      instr_ready     = drdy;
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
      if (rs) begin
         mem_addr_q.delete();
         mem_due_q.delete();
         last_due = 0;
      end else if (mem_due_q.size() > 0 && mem_due_q[0] <= cyc) begin
         imem_resp_valid = 1'b1;
         imem_resp_data  = mem_word(mem_addr_q.pop_front());
         void'(mem_due_q.pop_front());
      end
      #1;
      if (!rs && imem_req_valid && imem_req_ready) begin
         due = cyc + lat;
         if (last_due >= due) due = last_due + 1;
         last_due = due;
         mem_addr_q.push_back(imem_req_addr);
         mem_due_q.push_back(due);
      end
   endtask

   // Monitor / scoreboard: expected stream is PC, PC+4, ... from the last
   // reset or redirect, each carrying the memory word at that PC.
   logic [31:0] exp_pc = RESET_PC;
   logic        fault_m = 1'b0;
   logic        hold = 1'b0;
   logic [31:0] hold_bits = '0;
   logic [31:0] hold_pc = '0;

   always @(negedge clk) begin
      exp_t e;
      #1;
      if (rst) begin
         chk("reset_outputs_zero",
             32'(|{imem_req_valid, imem_req_addr, instr_valid, instr_bits, instr_pc, misaligned_fault}), 0);
         exp_q.delete();
         exp_pc  = RESET_PC;
         fault_m = 1'b0;
         hold    = 1'b0;
      end else begin
         chk("misaligned_fault", 32'(misaligned_fault), 32'(fault_m));
         if (hold) begin
            chk("hold_valid", 32'(instr_valid), 1);
            chk("hold_bits", instr_bits, hold_bits);
            chk("hold_pc", instr_pc, hold_pc);
         end
         if (fault_m || redirect_valid) chk("no_req_when_blocked", 32'(imem_req_valid), 0);
         if (imem_req_valid) chk("req_addr_aligned", 32'(imem_req_addr[1:0]), 0);
         if (redirect_valid) begin
            exp_q.delete();
            exp_pc  = redirect_pc;
            fault_m = |redirect_pc[1:0];
            hold    = 1'b0;
         end else begin
            if (instr_valid && instr_ready) begin
               pops++;
               if (exp_q.size() == 0) begin
                  checks++;
                  fails++;
                  $display("FAIL unexpected_instr: got pc %h with nothing expected (cycle %0d)", instr_pc, cyc);
               end else begin
                  e = exp_q.pop_front();
                  chk("instr_pc", instr_pc, e.pc);
                  chk("instr_bits", instr_bits, e.bits);
               end
            end
            if (imem_req_valid && imem_req_ready) begin
               chk("req_addr", imem_req_addr, exp_pc);
               e.pc   = exp_pc;
               e.bits = mem_word(exp_pc);
               exp_q.push_back(e);
               exp_pc = exp_pc + 32'd4;
            end
            hold      = instr_valid && !instr_ready;
            hold_bits = instr_bits;
            hold_pc   = instr_pc;
         end
      end
   end

   initial begin
      logic [31:0] rp;
      bit          rv;
      int          p0;

      // Reset, then release with an always-ready memory and decoder.
      repeat (3) step(1, 0, 0, 1, 1, 1);
      step(0, 0, 0, 1, 1, 1);
      #1;
      chk("first_req_valid", 32'(imem_req_valid), 1);
      chk("first_req_addr", imem_req_addr, RESET_PC);
      chk("first_instr_valid", 32'(instr_valid), 0);
      p0 = pops;
      repeat (30) step(0, 0, 0, 1, 1, 1);
      chk("throughput_ok", 32'((pops - p0) >= 15), 1);

      // Decoder stalls: FIFO fills and requests stop.
      repeat (10) step(0, 0, 0, 1, 0, 1);
      #1;
      chk("stall_instr_valid", 32'(instr_valid), 1);
      chk("stall_req_dropped", 32'(imem_req_valid), 0);
      repeat (8) step(0, 0, 0, 1, 1, 1);

      // Two requests in flight with slow memory, then redirect.
      repeat (2) step(0, 0, 0, 1, 1, 3);
      step(0, 1, 32'h100, 1, 1, 3);
      repeat (10) step(0, 0, 0, 1, 1, 3);

      // Redirect coincident with responses and pops: FIFO empty afterwards.
      repeat (4) step(0, 0, 0, 1, 1, 1);
      step(0, 1, 32'h400, 1, 1, 1);
      step(0, 0, 0, 1, 1, 1);
      #1;
      chk("flush_empty", 32'(instr_valid), 0);
      repeat (6) step(0, 0, 0, 1, 1, 1);

      // Misaligned redirect stops fetch; an aligned one resumes it.
      step(0, 1, 32'h102, 1, 1, 1);
      step(0, 0, 0, 1, 1, 1);
      #1;
      chk("fault_set", 32'(misaligned_fault), 1);
      repeat (5) step(0, 0, 0, 1, 1, 1);
      step(0, 1, 32'h200, 1, 1, 1);
      step(0, 0, 0, 1, 1, 1);
      #1;
      chk("fault_cleared", 32'(misaligned_fault), 0);
      chk("resume_addr", imem_req_addr, 32'h200);
      repeat (6) step(0, 0, 0, 1, 1, 1);

      // PC wrap at the top of the address space, then reset mid-stream.
      step(0, 1, 32'hFFFF_FFF8, 1, 1, 1);
      repeat (8) step(0, 0, 0, 1, 1, 1);
      step(1, 0, 0, 1, 1, 1);
      step(0, 0, 0, 1, 1, 1);
      #1;
      chk("restart_addr", imem_req_addr, RESET_PC);
      repeat (6) step(0, 0, 0, 1, 1, 1);

      // Randomized traffic.
      for (int i = 0; i < 2000; i++) begin
         rv = ($urandom_range(0, 24) == 0);
         case ($urandom_range(0, 5))
            0:       rp = $urandom() | 32'h1;
            1:       rp = 32'hFFFF_FFF0 | ($urandom_range(0, 3) << 2);
            default: rp = $urandom() & 32'hFFFF_FFFC;
         endcase
         step($urandom_range(0, 199) == 0, rv, rp,
              $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
              int'($urandom_range(1, 3)));
      end

      // Drain: no new requests, decoder ready; every accepted word must arrive.
      repeat (12) step(0, 0, 0, 0, 1, 1);
      #1;
      chk("drain_complete", 32'(exp_q.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
`default_nettype wire
